// File: rtl/poly_solver_if.sv
// Handshake and data bundle for poly_solver.
// The master (controller) drives start, x and the packed coefficients;
// the slave (the evaluator) returns the registered result and status flags.
interface poly_solver_if #(
  parameter int DEG = 2,
  parameter int W   = 16,
  parameter int XW  = 8
);
  logic                 start;
  logic [XW-1:0]        x;
  logic [(DEG+1)*W-1:0] coeffs;
  logic [W-1:0]         result;
  logic                 zero;
  logic                 overflow;
  logic                 busy;
  logic                 completed;

  modport master (
    output start, x, coeffs,
    input  result, zero, overflow, busy, completed
  );

  modport slave (
    input  start, x, coeffs,
    output result, zero, overflow, busy, completed
  );
endinterface

// File: rtl/poly_solver.sv
// Horner-method polynomial evaluator: p(x) = c[DEG]*x^DEG + ... + c[0].
// One multiply-accumulate per clock; operands are latched when start is
// accepted, so the caller may change them freely while busy.
// Overflow is sticky over all steps of one evaluation.
module poly_solver #(
  parameter int DEG    = 2,
  parameter int W      = 16,
  parameter int XW     = 8,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  poly_solver_if.slave  bus
);

  // Full-precision width of acc*x + c, wide enough for either signedness.
  localparam int TW = W + XW + 1;
  localparam int IW = $clog2(DEG + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [XW-1:0]        x_q;
  logic [(DEG+1)*W-1:0] coeffs_q;
  logic [W-1:0]         acc_q;
  logic [IW-1:0]        idx_q;
  logic                 ovf_q;
  logic [W-1:0]         result_q;
  logic                 zero_q;
  logic                 overflow_q;
  logic                 busy_q;
  logic                 completed_q;

  logic [W-1:0]         c_sel;
  logic                 acc_sx, x_sx, c_sx;
  logic [TW-1:0]        acc_ext, x_ext, c_ext, t_full;
  logic                 step_ovf;
  logic [W-1:0]         acc_d;
  logic                 ovf_d;

  // One Horner step: extend operands to TW bits, multiply-accumulate, and
  // flag the step if the exact value does not fit back into W bits.
  always_comb begin
    c_sel   = coeffs_q[int'(idx_q) * W +: W];
    acc_sx  = (SIGNED != 0) && acc_q[W-1];
    x_sx    = (SIGNED != 0) && x_q[XW-1];
    c_sx    = (SIGNED != 0) && c_sel[W-1];
    acc_ext = {{(TW-W){acc_sx}}, acc_q};
    x_ext   = {{(TW-XW){x_sx}}, x_q};
    c_ext   = {{(TW-W){c_sx}}, c_sel};
    // Modulo-2^TW arithmetic is exact here because the true value fits TW bits.
    t_full  = acc_ext * x_ext + c_ext;
    if (SIGNED != 0) begin
      step_ovf = !((&t_full[TW-1:W-1]) || (~|t_full[TW-1:W-1]));
    end else begin
      step_ovf = |t_full[TW-1:W];
    end
    acc_d = t_full[W-1:0];
    ovf_d = ovf_q | step_ovf;
  end

  // Sequencer: accept in IDLE/DONE, run DEG steps, publish on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      coeffs_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      completed_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            x_q         <= bus.x;
            coeffs_q    <= bus.coeffs;
            acc_q       <= bus.coeffs[DEG*W +: W];
            idx_q       <= IW'(DEG - 1);
            ovf_q       <= 1'b0;
            busy_q      <= 1'b1;
            completed_q <= 1'b0;
            state_q     <= S_STEP;
          end
        end
        S_STEP: begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          if (idx_q == '0) begin
            result_q    <= acc_d;
            zero_q      <= (acc_d == '0);
            overflow_q  <= ovf_d;
            busy_q      <= 1'b0;
            completed_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          completed_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = busy_q;
  assign bus.completed = completed_q;

endmodule

// File: tb/tb_poly_solver.sv
// Bench for poly_solver: an unsigned and a signed instance (DEG=2, W=16,
// XW=8) checked against an integer Horner model with explicit range checks.
module tb_poly_solver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  poly_solver_if #(.DEG(2), .W(16), .XW(8)) u_if ();
  poly_solver_if #(.DEG(2), .W(16), .XW(8)) s_if ();

  poly_solver #(.DEG(2), .W(16), .XW(8), .SIGNED(0)) u_dut (
    .clk (clk), .rst (rst), .bus (u_if.slave)
  );
  poly_solver #(.DEG(2), .W(16), .XW(8), .SIGNED(1)) s_dut (
    .clk (clk), .rst (rst), .bus (s_if.slave)
  );

  // Reference: exact integer Horner evaluation, wrapping acc to 16 bits each step.
  function automatic void model(input bit sgn, input logic [7:0] xv,
                                input logic [47:0] cv,
                                output logic [15:0] res, output bit ovf);
    longint acc, t, xi, ci;
    logic [15:0] c16;
    xi  = sgn ? longint'($signed(xv)) : longint'(xv);
    c16 = cv[47:32];
    acc = sgn ? longint'($signed(c16)) : longint'(c16);
    ovf = 1'b0;
    for (int i = 1; i >= 0; i--) begin
      c16 = cv[i*16 +: 16];
      ci  = sgn ? longint'($signed(c16)) : longint'(c16);
      t   = acc * xi + ci;
      if (sgn) begin
        if (t < -32768 || t > 32767) ovf = 1'b1;
      end else begin
        if (t > 65535) ovf = 1'b1;
      end
      acc = t % 65536;
      if (acc < 0) acc += 65536;
      if (sgn && acc > 32767) acc -= 65536;
    end
    res = acc[15:0];
  endfunction

  task automatic go(input bit sd, input logic [7:0] xv, input logic [47:0] cv);
    if (sd) begin s_if.x = xv; s_if.coeffs = cv; s_if.start = 1'b1; end
    else    begin u_if.x = xv; u_if.coeffs = cv; u_if.start = 1'b1; end
    @(posedge clk); #1;
    u_if.start = 1'b0;
    s_if.start = 1'b0;
  endtask

  task automatic wait_done(input bit sd, output int n, output bit to);
    n  = 0;
    to = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      n++;
      if (sd ? s_if.completed : u_if.completed) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    u_if.start = 1'b1; u_if.x = 8'h0F; u_if.coeffs = {16'h0060, 16'h0003, 16'h0001};
    s_if.start = 1'b0; s_if.x = '0; s_if.coeffs = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({u_if.result, u_if.zero, u_if.overflow, u_if.busy, u_if.completed} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {u_if.result, u_if.zero, u_if.overflow, u_if.busy, u_if.completed});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    checks++;
    if (u_if.busy !== 1'b1) begin
      errors++; $display("FAIL reset_release_accept: busy=%b want 1", u_if.busy);
    end
  endtask

  task automatic test_nominal;
    int n; bit to;
    go(1'b0, 8'h0F, {16'h0060, 16'h0003, 16'h0001});
    checks++;
    if (u_if.busy !== 1'b1 || u_if.completed !== 1'b0) begin
      errors++; $display("FAIL nominal_busy: busy=%b completed=%b want 1/0", u_if.busy, u_if.completed);
    end
    wait_done(1'b0, n, to);
    checks++;
    if (to || n != 2) begin
      errors++; $display("FAIL nominal_latency: cycles=%0d timeout=%0d want 2", n, to);
    end
    checks++;
    if (u_if.result !== 16'h548E || u_if.zero !== 1'b0 || u_if.overflow !== 1'b0 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_result: res=%h z=%b o=%b busy=%b want 548e/0/0/0",
               u_if.result, u_if.zero, u_if.overflow, u_if.busy);
    end
  endtask

  task automatic test_overflow;
    int n; bit to;
    go(1'b0, 8'hFF, {16'h0060, 16'h0003, 16'h0001});
    wait_done(1'b0, n, to);
    checks++;
    if (to || u_if.result !== 16'h435E || u_if.overflow !== 1'b1 || u_if.zero !== 1'b0) begin
      errors++;
      $display("FAIL overflow_result: res=%h o=%b z=%b to=%0d want 435e/1/0",
               u_if.result, u_if.overflow, u_if.zero, to);
    end
    go(1'b0, 8'h0F, {16'h0060, 16'h0003, 16'h0001});
    checks++;
    if (u_if.completed !== 1'b0 || u_if.result !== 16'h435E || u_if.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_hold: completed=%b res=%h o=%b want 0/435e/1",
               u_if.completed, u_if.result, u_if.overflow);
    end
    wait_done(1'b0, n, to);
    checks++;
    if (to || u_if.result !== 16'h548E || u_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_rerun: res=%h o=%b want 548e/0", u_if.result, u_if.overflow);
    end
  endtask

  task automatic test_zero;
    int n; bit to;
    logic [31:0] r;
    r = $urandom;
    go(1'b0, 8'h00, {r, 16'h0000});
    wait_done(1'b0, n, to);
    checks++;
    if (to || u_if.result !== 16'h0000 || u_if.zero !== 1'b1 || u_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: res=%h z=%b o=%b want 0000/1/0", u_if.result, u_if.zero, u_if.overflow);
    end
  endtask

  task automatic test_signed;
    int n; bit to;
    go(1'b1, 8'hFF, {16'h0001, 16'hFFFC, 16'h0004});
    wait_done(1'b1, n, to);
    checks++;
    if (to || n != 2 || s_if.result !== 16'h0009 || s_if.overflow !== 1'b0 || s_if.zero !== 1'b0) begin
      errors++;
      $display("FAIL signed_neg1: res=%h o=%b z=%b n=%0d want 0009/0/0/2",
               s_if.result, s_if.overflow, s_if.zero, n);
    end
    go(1'b1, 8'h02, {16'h0001, 16'hFFFC, 16'h0004});
    wait_done(1'b1, n, to);
    checks++;
    if (to || s_if.result !== 16'h0000 || s_if.zero !== 1'b1 || s_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL signed_root: res=%h z=%b o=%b want 0000/1/0", s_if.result, s_if.zero, s_if.overflow);
    end
  endtask

  task automatic test_abort;
    go(1'b0, 8'h0F, {16'h0060, 16'h0003, 16'h0001});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (u_if.completed !== 1'b0 || u_if.result !== 16'h0 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: completed=%b res=%h busy=%b want 0/0000/0",
               u_if.completed, u_if.result, u_if.busy);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (u_if.completed !== 1'b0 || u_if.result !== 16'h0) begin
      errors++;
      $display("FAIL abort_stays_idle: completed=%b res=%h want 0/0000", u_if.completed, u_if.result);
    end
  endtask

  task automatic test_ignore;
    int n; bit to;
    logic [15:0] exp_r; bit exp_o;
    model(1'b0, 8'h0F, {16'h0060, 16'h0003, 16'h0001}, exp_r, exp_o);
    go(1'b0, 8'h0F, {16'h0060, 16'h0003, 16'h0001});
    u_if.start = 1'b1;
    u_if.x = 8'hFF;
    u_if.coeffs = {16'h1234, 16'h5678, 16'h9ABC};
    n = 0; to = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      n++;
      if (u_if.completed) begin to = 1'b0; break; end
    end
    u_if.start = 1'b0;
    checks++;
    if (to || n != 2 || u_if.result !== exp_r || u_if.overflow !== exp_o) begin
      errors++;
      $display("FAIL ignore_during_step: res=%h o=%b n=%0d want %h/%b/2",
               u_if.result, u_if.overflow, n, exp_r, exp_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n; bit to;
    logic [15:0] r1, r2; bit o1, o2;
    logic [47:0] c;
    logic [7:0] x1, x2;
    c = {16'($urandom), 16'($urandom), 16'($urandom)};
    x1 = 8'($urandom); x2 = 8'($urandom);
    model(1'b0, x1, c, r1, o1);
    model(1'b0, x2, c, r2, o2);
    u_if.x = x1; u_if.coeffs = c; u_if.start = 1'b1;
    @(posedge clk); #1;
    wait_done(1'b0, n, to);
    checks++;
    if (to || u_if.result !== r1 || u_if.overflow !== o1) begin
      errors++;
      $display("FAIL b2b_first: res=%h o=%b want %h/%b", u_if.result, u_if.overflow, r1, o1);
    end
    u_if.x = x2;
    @(posedge clk); #1;
    checks++;
    if (u_if.completed !== 1'b0 || u_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: completed=%b busy=%b want 0/1", u_if.completed, u_if.busy);
    end
    u_if.start = 1'b0;
    wait_done(1'b0, n, to);
    checks++;
    if (to || n != 2 || u_if.result !== r2 || u_if.overflow !== o2) begin
      errors++;
      $display("FAIL b2b_second: res=%h o=%b n=%0d want %h/%b/2", u_if.result, u_if.overflow, n, r2, o2);
    end
  endtask

  task automatic test_random;
    int n; bit to;
    logic [15:0] er; bit eo;
    logic [47:0] c;
    logic [7:0] xv;
    bit sd;
    for (int k = 0; k < 40; k++) begin
      sd = k[0];
      c  = {16'($urandom), 16'($urandom), 16'($urandom)};
      if ((k % 5) == 0) c[47:16] = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
      xv = 8'($urandom);
      model(sd, xv, c, er, eo);
      go(sd, xv, c);
      wait_done(sd, n, to);
      checks++;
      if (sd) begin
        if (to || s_if.result !== er || s_if.overflow !== eo || s_if.zero !== (er == 16'h0)) begin
          errors++;
          $display("FAIL random_signed[%0d]: x=%h c=%h res=%h o=%b z=%b want %h/%b",
                   k, xv, c, s_if.result, s_if.overflow, s_if.zero, er, eo);
        end
      end else begin
        if (to || u_if.result !== er || u_if.overflow !== eo || u_if.zero !== (er == 16'h0)) begin
          errors++;
          $display("FAIL random_unsigned[%0d]: x=%h c=%h res=%h o=%b z=%b want %h/%b",
                   k, xv, c, u_if.result, u_if.overflow, u_if.zero, er, eo);
        end
      end
    end
  endtask

  initial begin
    u_if.start = 1'b0; u_if.x = '0; u_if.coeffs = '0;
    s_if.start = 1'b0; s_if.x = '0; s_if.coeffs = '0;
    #1;
    test_reset();
    begin : drain
      int n; bit to;
      wait_done(1'b0, n, to);
      checks++;
      if (to || u_if.result !== 16'h548E) begin
        errors++; $display("FAIL reset_first_eval: res=%h want 548e", u_if.result);
      end
    end
    test_nominal();
    test_overflow();
    test_zero();
    test_signed();
    test_abort();
    test_ignore();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
